uart_recv: RTL and testbench

UART receive (RX) block: deserialises an asynchronous 8N1 serial line into bytes, each presented with a one-cycle valid strobe. It sits on the receive side of the link, opposite `uart_send`, and uses the same clock/baud parameterisation and bit timing. A `uart_send` → `uart_recv` loopback on the same `clk` must deliver every byte unchanged. Framing errors are flagged, and the block re-arms only once the line returns to idle.

---
 rtl/uart_recv_if.sv | 12 +
 rtl/uart_recv.sv | 121 ++++++++++++
 tb/tb_uart_recv.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_recv_if.sv
// Receive-side signal bundle for uart_recv: serial input in, byte/strobe/status out.
// master is the receiver itself, slave is whatever consumes its bytes.
interface uart_recv_if;
    logic       rxd;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (input rxd, output dout, output dout_valid, output frame_err, output rx_busy);
    modport slave  (output rxd, input dout, input dout_valid, input frame_err, input rx_busy);
endinterface

// File: rtl/uart_recv.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, framing-error
// detection and a BREAK state that waits for the line to return to idle.
module uart_recv #(
    parameter int unsigned CLK_FREQUENCY_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE        = 1_562_500
) (
    input  logic        clk,
    input  logic        rst,
    uart_recv_if.master rx
);
    localparam int unsigned BIT_CYCLES  = CLK_FREQUENCY_HZ / BAUD_RATE;
    localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
    localparam logic [31:0] BIT_LAST    = 32'(BIT_CYCLES - 1);
    localparam logic [31:0] HALF_LAST   = 32'(HALF_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic        s1_q, s1_d;
    logic        rxd_s_q, rxd_s_d;
    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;
    logic        frame_err_q, frame_err_d;

    always_comb begin
        s1_d         = rx.rxd;
        rxd_s_d      = s1_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        sh_d         = sh_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rxd_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Re-check the start bit at its centre so short glitches are dropped.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxd_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    sh_d  = {rxd_s_q, sh_q[7:1]};
                    cnt_d = '0;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_STOP: begin
                // Leave at mid-stop so a directly following start edge is caught.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        dout_d       = sh_q;
                        dout_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        frame_err_d  = 1'b1;
                        state_d      = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_BREAK: begin
                if (rxd_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= 1'b1;
            rxd_s_q      <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            sh_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            rxd_s_q      <= rxd_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sh_q         <= sh_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx.dout       = dout_q;
    assign rx.dout_valid = dout_valid_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.rx_busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_recv.sv
// Directed and randomized bench for uart_recv; a line-level sender model drives rxd
// and expected bytes/pulse times come from the frame arithmetic of the 8N1 format.
module tb_uart_recv;
    localparam int BIT  = 64;
    localparam int HALF = 32;
    localparam int LAT  = 2 + HALF + 9 * BIT;   // edge of the stop-bit sample

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_recv_if rx_if ();

    uart_recv #(.CLK_FREQUENCY_HZ(100_000_000), .BAUD_RATE(1_562_500)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every pulse and busy transition with its cycle stamp.
    logic [7:0] vq[$];
    int vt[$], et[$], rq[$], fq[$];
    int ovl = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (rx_if.dout_valid) begin vq.push_back(rx_if.dout); vt.push_back(cyc); end
        if (rx_if.frame_err) et.push_back(cyc);
        if (rx_if.dout_valid && rx_if.frame_err) ovl = ovl + 1;
        if (rx_if.rx_busy && !busy_prev) rq.push_back(cyc);
        if (!rx_if.rx_busy && busy_prev) fq.push_back(cyc);
        busy_prev = rx_if.rx_busy;
    end

    int tests = 0, fails = 0;
    int t0, t1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        vq.delete(); vt.delete(); et.delete(); rq.delete(); fq.delete();
    endtask

    // Sender model: start, 8 data bits LSB first, one stop bit of the given level.
    task automatic send(input logic [7:0] b, input logic stop, input int per);
        rx_if.rxd = 1'b0;
        t0 = cyc + 1;
        tick(per);
        for (int i = 0; i < 8; i++) begin
            rx_if.rxd = b[i];
            tick(per);
        end
        rx_if.rxd = stop;
        tick(per);
    endtask

    function automatic logic [31:0] qv(input int n);
        return (vq.size() > n) ? {24'h0, vq[n]} : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] qt(input int n);
        return (vt.size() > n) ? vt[n] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        logic [7:0] exp_b[$];
        logic [7:0] b;
        int per, gap;

        rx_if.rxd = 1'b1;
        tick(4);
        chk("rst_dout", rx_if.dout, 0);
        chk("rst_valid", rx_if.dout_valid, 0);
        chk("rst_ferr", rx_if.frame_err, 0);
        chk("rst_busy", rx_if.rx_busy, 0);
        rst = 1'b0;
        tick(4);

        // Single byte with exact timing
        clr();
        send(8'hA5, 1'b1, BIT);
        tick(40);
        chk("a5_count", vq.size(), 1);
        chk("a5_data", qv(0), 32'hA5);
        chk("a5_time", qt(0), t0 + LAT);
        chk("a5_ferr", et.size(), 0);
        chk("a5_busy_rise", (rq.size() > 0) ? rq[0] : -1, t0 + 2);
        chk("a5_busy_fall", (fq.size() > 0) ? fq[0] : -1, t0 + LAT);

        // Back-to-back 0x00, 0xFF
        clr();
        send(8'h00, 1'b1, BIT);
        send(8'hFF, 1'b1, BIT);
        tick(40);
        chk("b2b_count", vq.size(), 2);
        chk("b2b_d0", qv(0), 32'h00);
        chk("b2b_d1", qv(1), 32'hFF);
        chk("b2b_gap", qt(1) - qt(0), 10 * BIT);

        // Glitch
        clr();
        rx_if.rxd = 1'b0;
        t0 = cyc + 1;
        tick(20);
        rx_if.rxd = 1'b1;
        tick(60);
        chk("gl_valid", vq.size(), 0);
        chk("gl_ferr", et.size(), 0);
        chk("gl_dout", rx_if.dout, 32'hFF);
        chk("gl_busy", rx_if.rx_busy, 0);
        chk("gl_fall", (fq.size() > 0) && (fq[0] <= t0 + 35), 1);

        // Framing error then long low line
        clr();
        send(8'h12, 1'b1, BIT);
        send(8'h55, 1'b0, BIT);
        t1 = t0;
        tick(300);
        rx_if.rxd = 1'b1;
        tick(100);
        chk("fe_count", et.size(), 1);
        chk("fe_time", (et.size() > 0) ? et[0] : -1, t1 + LAT);
        chk("fe_valid", vq.size(), 1);
        chk("fe_dout", rx_if.dout, 32'h12);
        chk("fe_ovl", ovl, 0);
        send(8'h3C, 1'b1, BIT);
        tick(40);
        chk("fe_next", qv(1), 32'h3C);

        // Reset during data bit 4, line high
        clr();
        rx_if.rxd = 1'b0;
        tick(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_if.rxd = 1'b0;
            tick(BIT);
        end
        rx_if.rxd = 1'b1;
        tick(30);
        rst = 1'b1;
        tick(1);
        chk("mr_dout", rx_if.dout, 0);
        chk("mr_valid", rx_if.dout_valid, 0);
        chk("mr_ferr", rx_if.frame_err, 0);
        chk("mr_busy", rx_if.rx_busy, 0);
        rst = 1'b0;
        tick(700);
        chk("mr_nopulse", vq.size() + et.size(), 0);
        send(8'hC3, 1'b1, BIT);
        tick(40);
        chk("mr_next", qv(0), 32'hC3);

        // Random stream, sender baud within +-1.6%, gaps 0..3 cycles
        clr();
        for (int k = 0; k < 24; k++) begin
            b   = 8'($urandom);
            per = 63 + int'($urandom_range(0, 2));
            gap = int'($urandom_range(0, 3));
            exp_b.push_back(b);
            send(b, 1'b1, per);
            if (gap > 0) tick(gap);
        end
        tick(100);
        chk("rnd_count", vq.size(), exp_b.size());
        chk("rnd_ferr", et.size(), 0);
        foreach (exp_b[k]) chk($sformatf("rnd_byte%0d", k), qv(k), {24'h0, exp_b[k]});
        chk("ovl_total", ovl, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
